// File: rtl/ahb_arbiter_2m.sv
// ahb_arbiter_2m
// Two-master AHB-Lite arbiter in front of a single slave port.
//
// The address-phase owner (addr_owner_q) drives the slave address/control.
// Each transfer accepted on an hready edge moves that owner into the data
// phase (data_owner_q / data_valid_q). The data-phase owner drives hwdata
// and receives hready/hresp.
//
// Arbitration is round robin and runs only on edges with s_hready=1.
// Fixed-length and INCR bursts hold a lock, so a burst is never split.
// With no requests the bus stays parked on the last owner.
//
// Handshake: a master's transfer is accepted on a rising edge where its
// m_hready is 1. A master that requests but is neither the address owner
// nor the active data owner sees m_hready=0. It must hold its address and
// control until it is granted.
//
// Ports:
//   hclk, hresetn              clock, asynchronous active-low reset
//   m_haddr/htrans/hwrite/     master address-phase signals, master 0 in
//   hsize/hburst/hwdata        the low slice, master 1 in the high slice
//   m_hrdata                   slave read data, broadcast to both masters
//   m_hready, m_hresp          per-master transfer response
//   m_hgrant                   one-hot address-phase owner
//   s_hsel..s_hwdata           muxed slave-side request
//   s_hrdata, s_hready, s_hresp slave response
module ahb_arbiter_2m #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic [2*ADDR_WIDTH-1:0] m_haddr,
    input  logic [3:0]              m_htrans,
    input  logic [1:0]              m_hwrite,
    input  logic [5:0]              m_hsize,
    input  logic [5:0]              m_hburst,
    input  logic [2*DATA_WIDTH-1:0] m_hwdata,
    output logic [DATA_WIDTH-1:0]   m_hrdata,
    output logic [1:0]              m_hready,
    output logic [1:0]              m_hresp,
    output logic [1:0]              m_hgrant,
    output logic                    s_hsel,
    output logic [ADDR_WIDTH-1:0]   s_haddr,
    output logic [1:0]              s_htrans,
    output logic                    s_hwrite,
    output logic [2:0]              s_hsize,
    output logic [2:0]              s_hburst,
    output logic [DATA_WIDTH-1:0]   s_hwdata,
    input  logic [DATA_WIDTH-1:0]   s_hrdata,
    input  logic                    s_hready,
    input  logic                    s_hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    logic       addr_owner_q, addr_owner_d;
    logic       last_grant_q, last_grant_d;
    logic       data_owner_q, data_owner_d;
    logic       data_valid_q, data_valid_d;
    logic       burst_lock_q, burst_lock_d;
    logic [3:0] beat_cnt_q,   beat_cnt_d;

    logic [1:0] req;
    logic [1:0] own_htrans;
    logic [2:0] own_hburst;
    logic       next_owner;

    // A master requests while it drives NONSEQ or SEQ.
    assign req = {m_htrans[3], m_htrans[1]};

    assign own_htrans = addr_owner_q ? m_htrans[3:2] : m_htrans[1:0];
    assign own_hburst = addr_owner_q ? m_hburst[5:3] : m_hburst[2:0];

    // Slave-side muxing
    assign s_haddr  = addr_owner_q ? m_haddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : m_haddr[ADDR_WIDTH-1:0];
    assign s_htrans = own_htrans;
    assign s_hwrite = addr_owner_q ? m_hwrite[1] : m_hwrite[0];
    assign s_hsize  = addr_owner_q ? m_hsize[5:3] : m_hsize[2:0];
    assign s_hburst = own_hburst;
    assign s_hsel   = |own_htrans;
    assign s_hwdata = data_owner_q ? m_hwdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : m_hwdata[DATA_WIDTH-1:0];

    assign m_hrdata = s_hrdata;
    assign m_hgrant = addr_owner_q ? 2'b10 : 2'b01;

    // The active data owner sees the slave hready first. This covers the
    // cycle after a switch, when it is no longer the address owner. A
    // requester that holds neither phase is stalled.
    function automatic logic hready_for(input logic idx);
        logic r;
        if (data_valid_q && (data_owner_q == idx)) begin
            r = s_hready;
        end else if (addr_owner_q == idx) begin
            r = s_hready;
        end else if (req[idx]) begin
            r = 1'b0;
        end else begin
            r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        m_hready[0] = hready_for(1'b0);
        m_hready[1] = hready_for(1'b1);
        m_hresp[0]  = data_valid_q && !data_owner_q && s_hresp;
        m_hresp[1]  = data_valid_q &&  data_owner_q && s_hresp;
    end

    // Next-owner choice from the current requests (round robin on conflict).
    always_comb begin
        next_owner = addr_owner_q;
        unique case (req)
            2'b01:   next_owner = 1'b0;
            2'b10:   next_owner = 1'b1;
            2'b11:   next_owner = ~last_grant_q;
            default: next_owner = addr_owner_q;
        endcase
    end

    always_comb begin
        addr_owner_d = addr_owner_q;
        last_grant_d = last_grant_q;
        data_owner_d = data_owner_q;
        data_valid_d = data_valid_q;
        burst_lock_d = burst_lock_q;
        beat_cnt_d   = beat_cnt_q;

        // Everything advances only on an accepted edge. Wait states and
        // the first ERROR cycle freeze the arbiter.
        if (s_hready) begin
            data_owner_d = addr_owner_q;
            data_valid_d = req[addr_owner_q];

            unique case (own_htrans)
                HTRANS_IDLE: begin
                    burst_lock_d = 1'b0;
                    beat_cnt_d   = 4'd0;
                end
                HTRANS_BUSY: begin
                    // A BUSY beat keeps the count unchanged. An undefined-length
                    // burst stays locked while the owner is BUSY.
                    if (own_hburst == HBURST_INCR) begin
                        burst_lock_d = 1'b1;
                    end
                end
                HTRANS_NONSEQ: begin
                    unique case (own_hburst)
                        HBURST_INCR4, HBURST_WRAP4: begin
                            burst_lock_d = 1'b1;
                            beat_cnt_d   = 4'd3;
                        end
                        HBURST_INCR8, HBURST_WRAP8: begin
                            burst_lock_d = 1'b1;
                            beat_cnt_d   = 4'd7;
                        end
                        HBURST_INCR16, HBURST_WRAP16: begin
                            burst_lock_d = 1'b1;
                            beat_cnt_d   = 4'd15;
                        end
                        HBURST_INCR: begin
                            burst_lock_d = 1'b1;
                            beat_cnt_d   = 4'd0;
                        end
                        default: begin
                            burst_lock_d = 1'b0;
                            beat_cnt_d   = 4'd0;
                        end
                    endcase
                end
                HTRANS_SEQ: begin
                    if (own_hburst == HBURST_INCR) begin
                        burst_lock_d = 1'b1;
                    end else if (beat_cnt_q != 4'd0) begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                        if (beat_cnt_q == 4'd1) begin
                            burst_lock_d = 1'b0;
                        end
                    end
                end
                default: begin
                    burst_lock_d = burst_lock_q;
                end
            endcase

            // Re-arbitrate only when the lock updated on this edge is clear.
            if (!burst_lock_d && (next_owner != addr_owner_q)) begin
                addr_owner_d = next_owner;
                last_grant_d = next_owner;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_owner_q <= 1'b0;
            last_grant_q <= 1'b0;
            data_owner_q <= 1'b0;
            data_valid_q <= 1'b0;
            burst_lock_q <= 1'b0;
            beat_cnt_q   <= 4'd0;
        end else begin
            addr_owner_q <= addr_owner_d;
            last_grant_q <= last_grant_d;
            data_owner_q <= data_owner_d;
            data_valid_q <= data_valid_d;
            burst_lock_q <= burst_lock_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Testbench for ahb_arbiter_2m.
// Each table row gives one clock cycle: the master and slave inputs for that
// cycle, and the hand-computed outputs expected in the same cycle. Rows
// run in order, so arbiter state carries from one row to the next. A
// hand-written sequence then covers reset in the middle of an INCR8 burst.
module tb_ahb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [2:0] SG = 3'd0;
    localparam logic [2:0] I4 = 3'd3;
    localparam logic [2:0] I8 = 3'd5;

    localparam logic [31:0] WD0 = 32'hA5A5_A5A5;
    localparam logic [31:0] WD1 = 32'h5A5A_5A5A;

    logic            hclk;
    logic            hresetn;
    logic [2*AW-1:0] m_haddr;
    logic [3:0]      m_htrans;
    logic [1:0]      m_hwrite;
    logic [5:0]      m_hsize;
    logic [5:0]      m_hburst;
    logic [2*DW-1:0] m_hwdata;
    logic [DW-1:0]   m_hrdata;
    logic [1:0]      m_hready;
    logic [1:0]      m_hresp;
    logic [1:0]      m_hgrant;
    logic            s_hsel;
    logic [AW-1:0]   s_haddr;
    logic [1:0]      s_htrans;
    logic            s_hwrite;
    logic [2:0]      s_hsize;
    logic [2:0]      s_hburst;
    logic [DW-1:0]   s_hwdata;
    logic [DW-1:0]   s_hrdata;
    logic            s_hready;
    logic            s_hresp;

    int n_checks;
    int n_fail;

    ahb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .m_haddr  (m_haddr),
        .m_htrans (m_htrans),
        .m_hwrite (m_hwrite),
        .m_hsize  (m_hsize),
        .m_hburst (m_hburst),
        .m_hwdata (m_hwdata),
        .m_hrdata (m_hrdata),
        .m_hready (m_hready),
        .m_hresp  (m_hresp),
        .m_hgrant (m_hgrant),
        .s_hsel   (s_hsel),
        .s_haddr  (s_haddr),
        .s_htrans (s_htrans),
        .s_hwrite (s_hwrite),
        .s_hsize  (s_hsize),
        .s_hburst (s_hburst),
        .s_hwdata (s_hwdata),
        .s_hrdata (s_hrdata),
        .s_hready (s_hready),
        .s_hresp  (s_hresp)
    );

    // Clock
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [1:0]  t0, t1;
        logic [2:0]  b0, b1;
        logic [31:0] a0, a1;
        logic        srdy, sresp;
        logic [31:0] rdata;
        logic [1:0]  e_gnt, e_rdy, e_resp;
        logic [31:0] e_saddr, e_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [1:0] t0, input logic [2:0] b0, input logic [31:0] a0,
        input logic [1:0] t1, input logic [2:0] b1, input logic [31:0] a1,
        input logic srdy, input logic sresp, input logic [31:0] rdata,
        input logic [1:0] e_gnt, input logic [1:0] e_rdy, input logic [1:0] e_resp,
        input logic [31:0] e_saddr, input logic [31:0] e_wdata);
        vec_t v;
        v.t0 = t0; v.b0 = b0; v.a0 = a0;
        v.t1 = t1; v.b1 = b1; v.a1 = a1;
        v.srdy = srdy; v.sresp = sresp; v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_rdy = e_rdy; v.e_resp = e_resp;
        v.e_saddr = e_saddr; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m_htrans = {v.t1, v.t0};
        m_hburst = {v.b1, v.b0};
        m_haddr  = {v.a1, v.a0};
        s_hready = v.srdy;
        s_hresp  = v.sresp;
        s_hrdata = v.rdata;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        logic [1:0] e_trans;
        logic [2:0] e_burst;
        e_trans = v.e_gnt[1] ? v.t1 : v.t0;
        e_burst = v.e_gnt[1] ? v.b1 : v.b0;
        chk({tag, " hgrant"},  32'(m_hgrant), 32'(v.e_gnt));
        chk({tag, " hready"},  32'(m_hready), 32'(v.e_rdy));
        chk({tag, " hresp"},   32'(m_hresp),  32'(v.e_resp));
        chk({tag, " s_haddr"}, s_haddr,       v.e_saddr);
        chk({tag, " s_htrans"}, 32'(s_htrans), 32'(e_trans));
        chk({tag, " s_hburst"}, 32'(s_hburst), 32'(e_burst));
        chk({tag, " s_hsel"},  32'(s_hsel),   32'(|e_trans));
        // Master 0 writes and master 1 reads throughout.
        chk({tag, " s_hwrite"}, 32'(s_hwrite), 32'(v.e_gnt[0]));
        chk({tag, " s_hwdata"}, s_hwdata,     v.e_wdata);
        chk({tag, " m_hrdata"}, m_hrdata,     v.rdata);
    endtask

    // Drive a row just after the rising edge, check it on the falling edge,
    // then move to just after the next rising edge.
    task automatic apply(input string tag, input vec_t v);
        drive(v);
        @(negedge hclk);
        check_vec(tag, v);
        @(posedge hclk);
        #1;
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;

        m_hwrite = 2'b01;
        m_hsize  = {3'b010, 3'b010};
        m_hwdata = {WD1, WD0};
        m_htrans = {ID, ID};
        m_hburst = {SG, SG};
        m_haddr  = {32'h0000_0999, 32'h0000_0100};
        s_hrdata = 32'h0;
        s_hready = 1'b1;
        s_hresp  = 1'b1;
        hresetn  = 1'b0;

        // Reset state. s_hresp is held high to show it is gated off.
        repeat (2) @(posedge hclk);
        #1;
        chk("reset hgrant",  32'(m_hgrant), 32'h1);
        chk("reset hready",  32'(m_hready), 32'h3);
        chk("reset hresp",   32'(m_hresp),  32'h0);
        chk("reset s_haddr", s_haddr,       32'h100);
        chk("reset s_hwdata", s_hwdata,     WD0);
        s_hresp = 1'b0;
        hresetn = 1'b1;

        // Columns: M0 trans/burst/addr, M1 trans/burst/addr, s_hready, s_hresp,
        // s_hrdata | expected hgrant, hready, hresp, s_haddr, s_hwdata.
        // Single write from M0.
        vecs.push_back(mk(NS, SG, 32'h100, ID, SG, 32'h0,   1, 0, 32'h11, 2'b01, 2'b11, 2'b00, 32'h100, WD0));
        vecs.push_back(mk(ID, SG, 32'h0,   ID, SG, 32'h0,   1, 0, 32'h22, 2'b01, 2'b11, 2'b00, 32'h0,   WD0));
        // Both request: M1 wins after M0's beat, then the grant alternates.
        vecs.push_back(mk(NS, SG, 32'h110, NS, SG, 32'h300, 1, 0, 32'h33, 2'b01, 2'b01, 2'b00, 32'h110, WD0));
        vecs.push_back(mk(NS, SG, 32'h114, NS, SG, 32'h300, 1, 0, 32'h44, 2'b10, 2'b11, 2'b00, 32'h300, WD0));
        vecs.push_back(mk(NS, SG, 32'h114, NS, SG, 32'h304, 1, 0, 32'h55, 2'b01, 2'b11, 2'b00, 32'h114, WD1));
        vecs.push_back(mk(ID, SG, 32'h0,   NS, SG, 32'h304, 1, 0, 32'h66, 2'b10, 2'b11, 2'b00, 32'h304, WD0));
        vecs.push_back(mk(ID, SG, 32'h0,   ID, SG, 32'h0,   1, 0, 32'h77, 2'b10, 2'b11, 2'b00, 32'h0,   WD1));
        // M0 INCR4 taken from the parked M1. M1 waits through the whole burst.
        vecs.push_back(mk(NS, I4, 32'h200, ID, SG, 32'h0,   1, 0, 32'h88, 2'b10, 2'b10, 2'b00, 32'h0,   WD1));
        vecs.push_back(mk(NS, I4, 32'h200, ID, SG, 32'h0,   1, 0, 32'h99, 2'b01, 2'b11, 2'b00, 32'h200, WD1));
        vecs.push_back(mk(SQ, I4, 32'h204, NS, SG, 32'h400, 1, 0, 32'haa, 2'b01, 2'b01, 2'b00, 32'h204, WD0));
        vecs.push_back(mk(SQ, I4, 32'h208, NS, SG, 32'h400, 1, 0, 32'hbb, 2'b01, 2'b01, 2'b00, 32'h208, WD0));
        vecs.push_back(mk(SQ, I4, 32'h20c, NS, SG, 32'h400, 1, 0, 32'hcc, 2'b01, 2'b01, 2'b00, 32'h20c, WD0));
        vecs.push_back(mk(ID, SG, 32'h0,   NS, SG, 32'h400, 1, 0, 32'hdd, 2'b10, 2'b11, 2'b00, 32'h400, WD0));
        // Two wait states on M1's read while M0 requests.
        vecs.push_back(mk(NS, SG, 32'h500, ID, SG, 32'h0,   0, 0, 32'hee, 2'b10, 2'b00, 2'b00, 32'h0,   WD1));
        vecs.push_back(mk(NS, SG, 32'h500, ID, SG, 32'h0,   0, 0, 32'hff, 2'b10, 2'b00, 2'b00, 32'h0,   WD1));
        vecs.push_back(mk(NS, SG, 32'h500, ID, SG, 32'h0,   1, 0, 32'hdeadbeef, 2'b10, 2'b10, 2'b00, 32'h0, WD1));
        vecs.push_back(mk(NS, SG, 32'h500, ID, SG, 32'h0,   1, 0, 32'h101, 2'b01, 2'b11, 2'b00, 32'h500, WD1));
        vecs.push_back(mk(ID, SG, 32'h0,   ID, SG, 32'h0,   1, 0, 32'h202, 2'b01, 2'b11, 2'b00, 32'h0,   WD0));
        // ERROR on M0's data phase while M1 holds the address phase.
        vecs.push_back(mk(NS, SG, 32'h600, NS, SG, 32'h700, 1, 0, 32'h303, 2'b01, 2'b01, 2'b00, 32'h600, WD0));
        vecs.push_back(mk(ID, SG, 32'h0,   NS, SG, 32'h700, 0, 1, 32'h404, 2'b10, 2'b00, 2'b01, 32'h700, WD0));
        vecs.push_back(mk(ID, SG, 32'h0,   NS, SG, 32'h700, 1, 1, 32'h505, 2'b10, 2'b11, 2'b01, 32'h700, WD0));
        vecs.push_back(mk(ID, SG, 32'h0,   ID, SG, 32'h0,   1, 0, 32'h606, 2'b10, 2'b11, 2'b00, 32'h0,   WD1));

        foreach (vecs[i]) begin
            apply($sformatf("v%0d", i), vecs[i]);
        end

        // Reset in the middle of an INCR8 from M1, while M0 is waiting.
        apply("incr8 nseq", mk(ID, SG, 32'h0,   NS, I8, 32'h800, 1, 0, 32'h1, 2'b10, 2'b11, 2'b00, 32'h800, WD1));
        apply("incr8 seq1", mk(NS, SG, 32'ha00, SQ, I8, 32'h804, 1, 0, 32'h2, 2'b10, 2'b10, 2'b00, 32'h804, WD1));
        v = mk(NS, SG, 32'ha00, SQ, I8, 32'h808, 1, 0, 32'h3, 2'b10, 2'b10, 2'b00, 32'h808, WD1);
        drive(v);
        @(negedge hclk);
        check_vec("incr8 seq2", v);
        #1;
        hresetn  = 1'b0;
        m_htrans = {ID, ID};
        s_hresp  = 1'b1;
        #1;
        chk("midreset hgrant", 32'(m_hgrant), 32'h1);
        chk("midreset hready", 32'(m_hready), 32'h3);
        chk("midreset hresp",  32'(m_hresp),  32'h0);
        chk("midreset s_hwdata", s_hwdata,    WD0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        s_hresp = 1'b0;
        // M0 is granted first. The conflict then goes to M1 because
        // last_grant restarted at 0.
        apply("post r0", mk(NS, SG, 32'ha00, NS, SG, 32'h808, 1, 0, 32'h4, 2'b01, 2'b01, 2'b00, 32'ha00, WD0));
        apply("post r1", mk(ID, SG, 32'h0,   NS, SG, 32'h900, 1, 0, 32'h5, 2'b10, 2'b11, 2'b00, 32'h900, WD0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_2m.md
Name: ahb_arbiter_2m

Overview:
- Shares one AHB-Lite slave port between two AHB-Lite masters.
- Tracks address-phase and data-phase ownership, muxes the address/control and write data, and routes hready/hresp back to the masters.
- Round-robin arbitration; bursts are never broken; the bus parks on the last owner.
- Sits between the masters and the slave-side decoder/interconnect.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width

Ports:
hclk  in  1  clock
hresetn  in  1  asynchronous active-low reset
m_haddr  in  2*ADDR_WIDTH  master addresses, master 0 in low slice
m_htrans  in  4  master htrans, 2 bits per master
m_hwrite  in  2  master hwrite
m_hsize  in  6  master hsize, 3 bits per master
m_hburst  in  6  master hburst, 3 bits per master
m_hwdata  in  2*DATA_WIDTH  master write data
m_hrdata  out  DATA_WIDTH  read data, broadcast to both masters
m_hready  out  2  per-master hready
m_hresp  out  2  per-master hresp
m_hgrant  out  2  one-hot address-phase owner
s_hsel  out  1  slave select
s_haddr  out  ADDR_WIDTH  muxed address
s_htrans  out  2  muxed htrans
s_hwrite  out  1  muxed hwrite
s_hsize  out  3  muxed hsize
s_hburst  out  3  muxed hburst
s_hwdata  out  DATA_WIDTH  muxed write data
s_hrdata  in  DATA_WIDTH  slave read data
s_hready  in  1  slave hready (bus ready)
s_hresp  in  1  slave response, 1 = ERROR

Behaviour:
- State: addr_owner (1b), last_grant (1b), data_owner (1b), data_valid (1b), burst_lock (1b), beat_cnt (4b).
- Reset values:
  - All state registers are 0.
  - m_hgrant = 2'b01; m_hready = 2'b11; m_hresp = 0.
  - s_* outputs follow master 0 combinationally.
- Request: req[i] = m_htrans[i][1] (NONSEQ or SEQ).
- Slave-side outputs:
  - s_haddr, s_htrans, s_hwrite, s_hsize and s_hburst select addr_owner combinationally; s_hsel = |s_htrans.
  - s_hwdata selects data_owner.
- Data phase:
  - On an edge with s_hready=1: data_owner <= addr_owner; data_valid <= req[addr_owner].
  - With s_hready=0, the data phase holds.
- m_hready[i]:
  - i == data_owner with data_valid: s_hready.
  - Otherwise, i == addr_owner: s_hready.
  - Otherwise req[i]=1 (waiting): 0, so the master is stalled and holds its address.
  - Otherwise: 1.
- m_hresp[i] = s_hresp only when i == data_owner && data_valid; otherwise 0.
- m_hrdata = s_hrdata.
- Burst lock (evaluated on edges with s_hready=1):
  - NONSEQ with hburst in {INCR4, WRAP4, INCR8, WRAP8, INCR16, WRAP16}: burst_lock=1, beat_cnt = beats-1 (3, 7 or 15).
  - Each accepted SEQ decrements beat_cnt; lock clears when SEQ is accepted with beat_cnt==1.
  - Each cycle where the owner drives BUSY leaves the count unchanged.
  - INCR (undefined length): lock=1 while the owner drives NONSEQ/SEQ/BUSY with hburst=INCR; clears when the owner drives IDLE or NONSEQ with another hburst.
  - SINGLE: no lock.
- Arbitration: the owner may change only on an edge with s_hready=1 and no lock in force after that edge's update.
  - Next owner = the requester, if exactly one master requests.
  - If both request: !last_grant.
  - If none request: unchanged (park).
  - When the owner changes, last_grant <= new owner.
- Switch timing: a waiting master's NONSEQ reaches s_haddr in the cycle after the switch edge and completes when s_hready=1 in that cycle.
- s_hready=0: no ownership, lock or counter change; this covers wait states and the first ERROR cycle.
- ERROR: the two-cycle response is routed to the data owner only. The burst lock is not cleared by ERROR; the master's next NONSEQ/IDLE governs it.
- Reset mid-transfer: all state returns to reset values immediately (asynchronous).

Test Plan:
- M0 single NONSEQ write, addr 0x100, data 0xA5A5A5A5, M1 idle -> s_haddr=0x100 in cycle 0, s_hwdata=0xA5A5A5A5 in cycle 1, m_hgrant stays 01.
- Both issue NONSEQ SINGLE in the same cycle after reset (last_grant=0) -> M1 granted after M0's beat. Then with both continuously requesting, grants alternate 01,10,01; the waiting master sees m_hready=0 until its beat.
- M0 INCR4 at 0x200, M1 requests at beat 2 -> four consecutive beats 0x200..0x20C from M0 on s_haddr, then M1 takes ownership; m_hready[1]=0 throughout.
- Slave inserts 2 wait states on M1 read data 0xDEADBEEF while M0 requests -> no grant change while s_hready=0; m_hrdata=0xDEADBEEF with m_hready[1]=1 on the completing cycle.
- Slave ERROR on M0's data phase while M1 is address owner -> m_hresp=2'b01 for 2 cycles, m_hready[0]=0 then 1, m_hresp[1]=0.
- Assert hresetn mid-INCR8 of M1 -> m_hgrant=01, m_hready=11 and burst lock cleared immediately; M0 is granted on its first request after release.
